// File: rtl/instruction_ram_pkg.sv
// rtl/instruction_ram_pkg.sv - shared opcodes, load FSM states and bytes-per-word helper
`ifndef INSTRUCTION_RAM_OPCODES
`define INSTRUCTION_RAM_OPCODES
`define NOP 8'h0F
`define LED 8'h05
`endif

package instruction_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } load_state_t;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/instruction_ram_if.sv
// rtl/instruction_ram_if.sv - fetch and byte-load port bundle for instruction_ram
interface instruction_ram_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oBusy;
  logic                  iLoadStart;
  logic [ADDR_WIDTH-1:0] iLoadCount;
  logic [7:0]            iLoadByte;
  logic                  iLoadValid;
  logic                  oLoadReady;
  logic                  oLoadDone;
  logic                  oLoadError;

  modport master (
    output iAddress, iLoadStart, iLoadCount, iLoadByte, iLoadValid,
    input  oInstruction, oBusy, oLoadReady, oLoadDone, oLoadError
  );

  modport slave (
    input  iAddress, iLoadStart, iLoadCount, iLoadByte, iLoadValid,
    output oInstruction, oBusy, oLoadReady, oLoadDone, oLoadError
  );
endinterface

// File: rtl/instruction_ram_word_assembler.sv
// rtl/instruction_ram_word_assembler.sv - MSB-first byte shifter with valid/ready intake
module word_assembler
  import instruction_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  word_last,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word_data
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  valid_q;
  logic                  accept;

  assign byte_ready = enable;
  assign accept     = byte_valid && enable;
  assign word_last  = accept && (count_q == LAST);
  assign word_valid = valid_q;
  assign word_data  = shift_q;

  // Truncating the shift drops the excess top bits of the first byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= word_last;
      if (clear) begin
        count_q <= '0;
      end else if (accept) begin
        shift_q <= DATA_WIDTH'({shift_q, byte_data});
        count_q <= word_last ? '0 : count_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/instruction_ram.sv
// rtl/instruction_ram.sv - run-time loadable instruction memory with registered fetch
module instruction_ram
  import instruction_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'({`LED, 24'hAA}),
  parameter logic [DATA_WIDTH-1:0] HOLD_WORD    = DATA_WIDTH'({`NOP, 24'd0})
) (
  input  logic             Clock,
  input  logic             Reset,
  instruction_ram_if.slave bus
);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  load_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, index_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  start, busy, mem_we;
  logic                  index_in_range, fetch_in_range;
  logic                  byte_ready, word_last, word_valid;
  logic [DATA_WIDTH-1:0] word_data;

  assign busy           = (state_q != ST_IDLE);
  assign start          = (state_q == ST_IDLE) && bus.iLoadStart;
  assign index_in_range = ({1'b0, index_q} < DEPTH_LIMIT);
  assign fetch_in_range = ({1'b0, bus.iAddress} < DEPTH_LIMIT);
  assign mem_we         = (state_q == ST_WRITE) && word_valid && index_in_range;

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_assembler (
    .clk        (Clock),
    .rst_n      (Reset),
    .enable     (state_q == ST_ASSEMBLE),
    .clear      (start),
    .byte_data  (bus.iLoadByte),
    .byte_valid (bus.iLoadValid),
    .byte_ready (byte_ready),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iLoadStart) begin
          state_d = (bus.iLoadCount != '0) ? ST_ASSEMBLE : ST_DONE;
        end
      end
      ST_ASSEMBLE: begin
        if (word_last) begin
          state_d = ST_WRITE;
        end
      end
      // Index never wraps: count is at most 2^ADDR_WIDTH-1
      ST_WRITE: begin
        state_d = ((index_q + ADDR_WIDTH'(1)) == count_q) ? ST_DONE : ST_ASSEMBLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      index_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (start) begin
        count_q <= bus.iLoadCount;
        index_q <= '0;
        error_q <= 1'b0;
      end else if (state_q == ST_WRITE) begin
        index_q <= index_q + ADDR_WIDTH'(1);
        if (!index_in_range) begin
          error_q <= 1'b1;
        end
      end
    end
  end

  // Array has no reset so contents survive an abandoned load
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[index_q[MEM_AW-1:0]] <= word_data;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      instr_q <= HOLD_WORD;
    end else if (busy) begin
      instr_q <= HOLD_WORD;
    end else if (fetch_in_range) begin
      instr_q <= mem[bus.iAddress[MEM_AW-1:0]];
    end else begin
      instr_q <= DEFAULT_WORD;
    end
  end

  assign bus.oInstruction = instr_q;
  assign bus.oBusy        = busy;
  assign bus.oLoadReady   = byte_ready;
  assign bus.oLoadDone    = (state_q == ST_DONE);
  assign bus.oLoadError   = error_q;
endmodule

// File: tb/tb_instruction_ram.sv
// tb/tb_instruction_ram.sv - scoreboard bench for instruction_ram at DEPTH 4 and 256
module tb_instruction_ram;
  localparam logic [27:0] HOLD = 28'hF000000;
  localparam logic [27:0] DFLT = 28'h50000AA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] load_count = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;

  always #5 clk = ~clk;

  instruction_ram_if #(.DATA_WIDTH(28), .ADDR_WIDTH(16)) ifa ();
  instruction_ram_if #(.DATA_WIDTH(28), .ADDR_WIDTH(16)) ifb ();

  assign ifa.iAddress   = addr;
  assign ifa.iLoadStart = load_start;
  assign ifa.iLoadCount = load_count;
  assign ifa.iLoadByte  = load_byte;
  assign ifa.iLoadValid = load_valid;
  assign ifb.iAddress   = addr;
  assign ifb.iLoadStart = load_start;
  assign ifb.iLoadCount = load_count;
  assign ifb.iLoadByte  = load_byte;
  assign ifb.iLoadValid = load_valid;

  instruction_ram #(.DEPTH(4)) dut_a (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (ifa.slave)
  );

  instruction_ram #(.DEPTH(256)) dut_b (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (ifb.slave)
  );

  typedef struct {
    bit          known;
    logic [27:0] val;
    int          inst;
    int          addr;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_a = 0;
  int          done_b = 0;
  exp_t        sb[$];
  int          faddr[$];
  logic [27:0] mm [2][256];
  bit          mk [2][256];
  int          depth_of [2] = '{4, 256};
  logic [27:0] wbuf [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.oLoadDone === 1'b1) done_a++;
    if (ifb.oLoadDone === 1'b1) done_b++;
  end

  // Addresses are driven on one falling edge and their data compared on the next
  task automatic fetch_seq();
    exp_t e;
    int   n;
    n = faddr.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        for (int k = 0; k < 2; k++) begin
          e = sb.pop_front();
          if (e.known) begin
            check($sformatf("fetch_%0d_d%0d", e.addr, depth_of[e.inst]),
                  (e.inst == 0) ? ifa.oInstruction : ifb.oInstruction, e.val);
          end
        end
      end
      if (i < n) begin
        addr = 16'(faddr[i]);
        for (int k = 0; k < 2; k++) begin
          e.inst = k;
          e.addr = faddr[i];
          if (faddr[i] >= depth_of[k]) begin
            e.known = 1'b1;
            e.val   = DFLT;
          end else begin
            e.known = mk[k][faddr[i]];
            e.val   = mm[k][faddr[i]];
          end
          sb.push_back(e);
        end
      end
    end
    faddr.delete();
  endtask

  task automatic load(input int cnt, input logic [3:0] junk, input bit toggle, input int stop_at);
    int          idx;
    int          nbytes;
    int          cyc;
    int          da;
    int          db;
    int          words;
    logic [31:0] full;
    idx = 0;
    cyc = 0;
    nbytes = (stop_at > 0) ? stop_at : cnt * 4;
    da = done_a;
    db = done_b;
    @(negedge clk);
    load_start = 1'b1;
    load_count = 16'(cnt);
    @(negedge clk);
    load_start = 1'b0;
    if (cnt == 0) begin
      check("done_zero_d4", ifa.oLoadDone, 1);
      check("done_zero_d256", ifb.oLoadDone, 1);
    end
    while (idx < nbytes && cyc < 400) begin
      full = {junk, wbuf[idx / 4]};
      load_byte = full[31 - 8 * (idx % 4) -: 8];
      load_valid = toggle ? cyc[0] : 1'b1;
      if (toggle) check("busy_hold", ifb.oBusy, 1);
      if (load_valid && ifa.oLoadReady) idx++;
      cyc++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check("bytes_sent", idx, nbytes);
    if (stop_at == 0) begin
      cyc = 0;
      while ((ifa.oBusy || ifb.oBusy) && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("busy_release_d4", ifa.oBusy, 0);
      check("busy_release_d256", ifb.oBusy, 0);
      check("done_pulses_d4", done_a - da, 1);
      check("done_pulses_d256", done_b - db, 1);
      check("hold_after_done", ifa.oInstruction, HOLD);
    end
    words = (stop_at > 0) ? stop_at / 4 : cnt;
    for (int w = 0; w < words; w++) begin
      for (int k = 0; k < 2; k++) begin
        if (w < depth_of[k]) begin
          mm[k][w] = wbuf[w];
          mk[k][w] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    addr = 16'd5;
    repeat (3) @(negedge clk);
    check("rst_instr_d4", ifa.oInstruction, HOLD);
    check("rst_instr_d256", ifb.oInstruction, HOLD);
    check("rst_busy", ifa.oBusy, 0);
    check("rst_ready", ifa.oLoadReady, 0);
    check("rst_done", ifb.oLoadDone, 0);
    check("rst_error", ifb.oLoadError, 0);
    rst_n = 1'b1;
    #1;
    check("hold_before_fetch", ifb.oInstruction, HOLD);
    faddr = '{5};
    fetch_seq();

    wbuf[0] = 28'h0AABBCC;
    wbuf[1] = 28'h1112233;
    load(2, 4'h0, 1'b0, 0);
    check("err_after_load_d4", ifa.oLoadError, 0);
    faddr = '{0, 1};
    fetch_seq();

    for (int i = 0; i < 6; i++) wbuf[i] = 28'h3C0FFE0 + 28'(i);
    load(6, 4'hA, 1'b0, 0);
    check("err_overflow_d4", ifa.oLoadError, 1);
    check("err_overflow_d256", ifb.oLoadError, 0);
    faddr = '{0, 1, 2, 3, 4, 5};
    fetch_seq();
    check("err_held_d4", ifa.oLoadError, 1);

    wbuf[0] = 28'h0AABBCC;
    wbuf[1] = 28'h1112233;
    load(2, 4'h0, 1'b1, 0);
    check("err_cleared_d4", ifa.oLoadError, 0);
    faddr = '{0, 1, 2, 3};
    fetch_seq();

    load(0, 4'h0, 1'b0, 0);
    check("err_zero_d4", ifa.oLoadError, 0);
    check("err_zero_d256", ifb.oLoadError, 0);
    faddr = '{0, 1, 2, 3};
    fetch_seq();

    wbuf[0] = 28'hEADBEEF;
    wbuf[1] = 28'h7654321;
    load(2, 4'hD, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_d4", ifa.oBusy, 0);
    check("midrst_busy_d256", ifb.oBusy, 0);
    check("midrst_ready", ifb.oLoadReady, 0);
    check("midrst_instr", ifb.oInstruction, HOLD);
    @(negedge clk);
    rst_n = 1'b1;
    faddr = '{0, 1, 300, 5};
    fetch_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
